// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe move entry path.
// Board cell encoding, FSM state encoding and the default debounce length.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    localparam int NUM_CELLS        = 9;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        CHECK,
        WRITE,
        REJECT,
        RELEASE
    } move_state_t;

    // Index of the set bit; only meaningful when exactly one bit is set.
    function automatic logic [3:0] onehot_index(input logic [NUM_CELLS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, synchronous active-low reset.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/move_entry.sv
// Debounces the nine cell buttons and turns one clean press into a single
// move strobe (empty cell, game running) or a single reject pulse.
module move_entry
    import tictactoe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                   ph1,
    input  logic                   ph2,
    input  logic                   reset,
    input  logic [NUM_CELLS-1:0]   keyRaw,
    input  logic [2*NUM_CELLS-1:0] gBoard,
    input  logic                   gameIsDone,
    output logic                   playerWrite,
    output logic [3:0]             playerInput,
    output logic                   moveRejected,
    output logic                   busy
);

    // All state advances on ph2; ph1 is carried for interface compatibility.
    logic unused_ph1;
    assign unused_ph1 = ph1;

    logic [NUM_CELLS-1:0] keySync;
    move_state_t          state, state_n;
    logic [3:0]           count, count_n;
    logic [3:0]           idx, idx_n;
    logic [NUM_CELLS-1:0] cap_mask;
    logic [3:0]           count_inc;

    sync2 #(.WIDTH(NUM_CELLS)) u_sync (
        .clk   (ph2),
        .reset (reset),
        .d     (keyRaw),
        .q     (keySync)
    );

    assign cap_mask  = NUM_CELLS'(1) << idx;
    assign count_inc = (count == 4'hF) ? count : count + 4'd1;

    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if ($onehot(keySync)) begin
                    idx_n   = onehot_index(keySync);
                    count_n = 4'd1;
                    state_n = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (keySync != cap_mask) begin
                    state_n = IDLE;
                end else begin
                    count_n = count_inc;
                    if (count_inc == 4'(DEBOUNCE_CYCLES)) state_n = CHECK;
                end
            end
            CHECK: begin
                // The only place the board and game status are looked at.
                if (gBoard[{idx, 1'b0} +: 2] == EMPTY && !gameIsDone)
                    state_n = WRITE;
                else
                    state_n = REJECT;
            end
            WRITE, REJECT: begin
                count_n = 4'd0;
                state_n = RELEASE;
            end
            RELEASE: begin
                if (keySync != '0) begin
                    count_n = 4'd0;
                end else begin
                    count_n = count_inc;
                    if (count_inc == 4'(DEBOUNCE_CYCLES)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge ph2) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            idx          <= 4'd0;
            playerWrite  <= 1'b0;
            playerInput  <= 4'd0;
            moveRejected <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            idx          <= idx_n;
            playerWrite  <= (state_n == WRITE);
            moveRejected <= (state_n == REJECT);
            busy         <= (state_n != IDLE);
            if (state_n == WRITE) playerInput <= idx_n;
        end
    end

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry: press, reject, bounce, multi-key, game over
// and reset-abort scenarios with hand-computed strobe timing.
module tb_move_entry;

    logic       ph1;
    logic       ph2;
    logic       rst_n;
    logic [8:0] key_raw;
    logic [17:0] g_board;
    logic       game_done;
    logic       player_write;
    logic [3:0] player_input;
    logic       move_rejected;
    logic       busy;

    int n_vec;
    int n_bad;

    move_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .ph1          (ph1),
        .ph2          (ph2),
        .reset        (rst_n),
        .keyRaw       (key_raw),
        .gBoard       (g_board),
        .gameIsDone   (game_done),
        .playerWrite  (player_write),
        .playerInput  (player_input),
        .moveRejected (move_rejected),
        .busy         (busy)
    );

    // Non-overlapping two-phase clock, 10 time-unit period.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #3 ph1 = 1'b0;
            #1 ph2 = 1'b1;
            #3 ph2 = 1'b0;
            #2;
        end
    end

    task automatic tick();
        @(posedge ph2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold a key pattern and record strobe counts and the tick of the first ones.
    task automatic hold_key(input logic [8:0] k, input int cycles,
                            output int nw, output int nr,
                            output int first_w, output int first_r,
                            output logic [3:0] pin);
        nw = 0; nr = 0; first_w = -1; first_r = -1; pin = '0;
        key_raw = k;
        for (int i = 1; i <= cycles; i++) begin
            tick();
            if (player_write) begin
                nw++;
                if (first_w < 0) first_w = i;
                pin = player_input;
            end
            if (move_rejected) begin
                nr++;
                if (first_r < 0) first_r = i;
            end
        end
    endtask

    task automatic settle(output int strobes);
        strobes = 0;
        key_raw = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (player_write || move_rejected) strobes++;
        end
    endtask

    int nw, nr, fw, fr, st, bounce_strobes;
    logic [3:0] pin;
    logic [8:0] bounce_seq [5];

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        key_raw = '0;
        g_board = '0;
        game_done = 1'b0;
        bounce_seq = '{9'h004, 9'h000, 9'h004, 9'h004, 9'h000};

        tick();
        tick();
        check("reset_write", 32'(player_write), 32'd0);
        check("reset_input", 32'(player_input), 32'd0);
        check("reset_reject", 32'(move_rejected), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Clean press of cell 4 on an empty board.
        hold_key(9'h010, 20, nw, nr, fw, fr, pin);
        check("press4_writes", 32'(nw), 32'd1);
        check("press4_latency", 32'(fw), 32'd7);
        check("press4_input", 32'(pin), 32'd4);
        check("press4_rejects", 32'(nr), 32'd0);
        settle(st);
        check("press4_release_strobes", 32'(st), 32'd0);
        check("press4_idle_busy", 32'(busy), 32'd0);
        check("press4_input_held", 32'(player_input), 32'd4);

        // Occupied cell 4.
        g_board = 18'h00100;
        hold_key(9'h010, 20, nw, nr, fw, fr, pin);
        check("occupied_rejects", 32'(nr), 32'd1);
        check("occupied_reject_latency", 32'(fr), 32'd7);
        check("occupied_writes", 32'(nw), 32'd0);
        g_board = '0;
        settle(st);

        // Bouncing key 2, then stable.
        bounce_strobes = 0;
        for (int i = 0; i < 5; i++) begin
            key_raw = bounce_seq[i];
            tick();
            if (player_write || move_rejected) bounce_strobes++;
        end
        check("bounce_no_strobe", 32'(bounce_strobes), 32'd0);
        hold_key(9'h004, 20, nw, nr, fw, fr, pin);
        check("bounce_writes", 32'(nw), 32'd1);
        check("bounce_latency", 32'(fw), 32'd7);
        check("bounce_input", 32'(pin), 32'd2);
        settle(st);

        // Two keys at once are ignored; dropping to one key is accepted.
        hold_key(9'h003, 12, nw, nr, fw, fr, pin);
        check("multi_writes", 32'(nw), 32'd0);
        check("multi_rejects", 32'(nr), 32'd0);
        check("multi_busy", 32'(busy), 32'd0);
        hold_key(9'h001, 20, nw, nr, fw, fr, pin);
        check("single_writes", 32'(nw), 32'd1);
        check("single_latency", 32'(fw), 32'd7);
        check("single_input", 32'(pin), 32'd0);
        settle(st);

        // Game over: empty cell still rejected.
        game_done = 1'b1;
        hold_key(9'h020, 20, nw, nr, fw, fr, pin);
        check("done_rejects", 32'(nr), 32'd1);
        check("done_writes", 32'(nw), 32'd0);
        game_done = 1'b0;
        settle(st);

        // Reset while the strobe is up kills it on the next edge.
        hold_key(9'h002, 7, nw, nr, fw, fr, pin);
        check("wreset_strobe_up", 32'(player_write), 32'd1);
        check("wreset_input_up", 32'(player_input), 32'd1);
        rst_n = 1'b0;
        tick();
        check("wreset_write", 32'(player_write), 32'd0);
        check("wreset_input", 32'(player_input), 32'd0);
        check("wreset_busy", 32'(busy), 32'd0);
        key_raw = '0;
        rst_n = 1'b1;
        settle(st);
        check("wreset_after_strobes", 32'(st), 32'd0);

        // Reset during debounce with the key held; press is re-debounced.
        hold_key(9'h040, 4, nw, nr, fw, fr, pin);
        check("dreset_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("dreset_write", 32'(player_write), 32'd0);
        check("dreset_reject", 32'(move_rejected), 32'd0);
        check("dreset_busy", 32'(busy), 32'd0);
        check("dreset_input", 32'(player_input), 32'd0);
        rst_n = 1'b1;
        hold_key(9'h040, 20, nw, nr, fw, fr, pin);
        check("dreset_writes", 32'(nw), 32'd1);
        check("dreset_latency", 32'(fw), 32'd7);
        check("dreset_input_after", 32'(pin), 32'd6);
        settle(st);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
